// File: rtl/dcache_line_mover_if.sv
// ---------------------------------------------------------------------------
// dcache_line_mover_if
//
// Purpose: bundles every bus of the data-cache line mover into one place.
// That covers the miss-request handshake, the line-wide BRAM read and write
// ports, the read-burst channel and the write-burst channel.
//
// Port summary (seen from the mover, i.e. the master modport):
//   req_*    miss request in, with req_ready out
//   bram_*   BRAM read address/enable out, full-line read data in;
//            BRAM write address/enable/full-line select/data out
//   rd_*     read burst: request/address out, grant and beats in
//   wr_*     write burst: request/address/beats out, grant/ready/done in
//   done     one-cycle pulse when a refilled line lands in BRAM
// The slave modport is the mirror image, used by the surrounding system.
// ---------------------------------------------------------------------------
interface dcache_line_mover_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int LINE_WORDS = 8
);
    localparam int LINE_BITS = 32 * LINE_WORDS;

    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-4:0] req_index;
    logic [31:0]           req_refill_addr;
    logic                  req_dirty;
    logic [31:0]           req_victim_addr;

    logic [ADDR_WIDTH-1:0] bram_raddr;
    logic                  bram_re;
    logic [LINE_BITS-1:0]  bram_dout_all;
    logic [ADDR_WIDTH-1:0] bram_waddr;
    logic                  bram_we;
    logic                  bram_hit_write;
    logic [LINE_BITS-1:0]  bram_din_all;

    logic                  rd_req;
    logic [31:0]           rd_addr;
    logic                  rd_gnt;
    logic                  rd_valid;
    logic [31:0]           rd_data;
    logic                  rd_last;

    logic                  wr_req;
    logic [31:0]           wr_addr;
    logic                  wr_gnt;
    logic                  wr_valid;
    logic [31:0]           wr_data;
    logic                  wr_last;
    logic                  wr_ready;
    logic                  wr_done;

    logic                  done;

    modport master (
        input  req_valid, req_index, req_refill_addr, req_dirty, req_victim_addr,
        output req_ready,
        output bram_raddr, bram_re, bram_waddr, bram_we, bram_hit_write, bram_din_all,
        input  bram_dout_all,
        output rd_req, rd_addr,
        input  rd_gnt, rd_valid, rd_data, rd_last,
        output wr_req, wr_addr, wr_valid, wr_data, wr_last,
        input  wr_gnt, wr_ready, wr_done,
        output done
    );

    modport slave (
        output req_valid, req_index, req_refill_addr, req_dirty, req_victim_addr,
        input  req_ready,
        input  bram_raddr, bram_re, bram_waddr, bram_we, bram_hit_write, bram_din_all,
        output bram_dout_all,
        input  rd_req, rd_addr,
        output rd_gnt, rd_valid, rd_data, rd_last,
        input  wr_req, wr_addr, wr_valid, wr_data, wr_last,
        output wr_gnt, wr_ready, wr_done,
        input  done
    );
endinterface

// File: rtl/dcache_line_mover.sv
// ---------------------------------------------------------------------------
// dcache_line_mover
//
// Purpose: services one data-cache miss at a time. When the victim line is
// dirty, the mover reads it out of the line-wide BRAM and streams it to memory
// as a write burst. It then fetches the refill line with a read burst, writes
// the whole line back into BRAM in a single cycle and pulses done.
//
// Ports:
//   clk  single clock, rising edge
//   rst  asynchronous, active-high reset
//   bus  dcache_line_mover_if.master; carries the request handshake, the
//        BRAM ports and the read/write burst channels
// ---------------------------------------------------------------------------
module dcache_line_mover #(
    parameter int ADDR_WIDTH = 10,
    parameter int LINE_WORDS = 8
) (
    input  logic                clk,
    input  logic                rst,
    dcache_line_mover_if.master bus
);
    localparam int LINE_BITS = 32 * LINE_WORDS;
    localparam int CNT_W     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

    typedef enum logic [3:0] {
        IDLE,
        WB_RD,
        WB_CAP,
        WB_ADDR,
        WB_DATA,
        WB_RESP,
        RF_ADDR,
        RF_DATA,
        RF_WR,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-4:0] index_q, index_d;
    logic [26:0]           refill_q, refill_d;
    logic [26:0]           victim_q, victim_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [LINE_BITS-1:0]  line_buf_q, line_buf_d;

    // The five byte-offset bits of both line addresses are dropped on purpose.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{bus.req_refill_addr[4:0], bus.req_victim_addr[4:0]};

    // Addresses and data are driven straight from the latched request and the
    // line buffer, so they stay stable in every state that does not use them.
    assign bus.bram_raddr   = {index_q, 3'b000};
    assign bus.bram_waddr   = {index_q, 3'b000};
    assign bus.bram_din_all = line_buf_q;
    assign bus.rd_addr      = {refill_q, 5'b00000};
    assign bus.wr_addr      = {victim_q, 5'b00000};
    assign bus.wr_data      = line_buf_q[{cnt_q, 5'b00000} +: 32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            index_q    <= '0;
            refill_q   <= '0;
            victim_q   <= '0;
            cnt_q      <= '0;
            line_buf_q <= '0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            refill_q   <= refill_d;
            victim_q   <= victim_d;
            cnt_q      <= cnt_d;
            line_buf_q <= line_buf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        refill_d   = refill_q;
        victim_d   = victim_q;
        cnt_d      = cnt_q;
        line_buf_d = line_buf_q;

        bus.req_ready      = 1'b0;
        bus.bram_re        = 1'b0;
        bus.bram_we        = 1'b0;
        bus.bram_hit_write = 1'b0;
        bus.rd_req         = 1'b0;
        bus.wr_req         = 1'b0;
        bus.wr_valid       = 1'b0;
        bus.wr_last        = 1'b0;
        bus.done           = 1'b0;

        unique case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    index_d  = bus.req_index;
                    refill_d = bus.req_refill_addr[31:5];
                    victim_d = bus.req_victim_addr[31:5];
                    cnt_d    = '0;
                    state_d  = bus.req_dirty ? WB_RD : RF_ADDR;
                end
            end

            WB_RD: begin
                bus.bram_re = 1'b1;
                state_d     = WB_CAP;
            end

            // BRAM read data arrives one cycle after the enable.
            WB_CAP: begin
                line_buf_d = bus.bram_dout_all;
                state_d    = WB_ADDR;
            end

            WB_ADDR: begin
                bus.wr_req = 1'b1;
                if (bus.wr_gnt) begin
                    cnt_d   = '0;
                    state_d = WB_DATA;
                end
            end

            WB_DATA: begin
                bus.wr_valid = 1'b1;
                bus.wr_last  = (cnt_q == LAST_BEAT);
                if (bus.wr_ready) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = WB_RESP;
                    end
                end
            end

            WB_RESP: begin
                if (bus.wr_done) begin
                    state_d = RF_ADDR;
                end
            end

            RF_ADDR: begin
                bus.rd_req = 1'b1;
                if (bus.rd_gnt) begin
                    cnt_d   = '0;
                    state_d = RF_DATA;
                end
            end

            // An early rd_last ends the burst; words not yet received keep
            // whatever the buffer held before.
            RF_DATA: begin
                if (bus.rd_valid) begin
                    line_buf_d[{cnt_q, 5'b00000} +: 32] = bus.rd_data;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (bus.rd_last || (cnt_q == LAST_BEAT)) begin
                        state_d = RF_WR;
                    end
                end
            end

            RF_WR: begin
                bus.bram_we        = 1'b1;
                bus.bram_hit_write = 1'b1;
                state_d            = DONE;
            end

            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule
